clk_div_prog: RTL and testbench

CLK_DIV_PROG -- requirements
Module: clk_div_prog

---
 rtl/clk_div_prog_if.sv | 32 +++
 rtl/clk_div_prog.sv | 139 +++++++++++++
 tb/tb_clk_div_prog.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// -----------------------------------------------------------------------------
// clk_div_prog_if
// Bundles the control and status signals of the programmable clock divider.
//   master : drives en, div_val, div_load, frame_len; observes the outputs
//   slave  : the divider itself (receives controls, drives tick, sclk_sq,
//            frame, div_ack, div_err, cnt)
// -----------------------------------------------------------------------------
interface clk_div_prog_if #(
    parameter int DIV_W = 8,
    parameter int FRM_W = 16
);
    logic             en;         // count enable, 0 freezes all counters
    logic [DIV_W-1:0] div_val;    // requested divisor (period in clk cycles)
    logic             div_load;   // one-cycle request to load div_val
    logic [FRM_W-1:0] frame_len;  // ticks per frame, 0 disables frame output
    logic             tick;       // one-clk pulse per divisor period
    logic             sclk_sq;    // square wave at clk/div
    logic             frame;      // pulse with the last tick of each frame
    logic             div_ack;    // pending divisor took effect
    logic             div_err;    // load request rejected
    logic [DIV_W-1:0] cnt;        // current cycle-counter value

    modport master (
        output en, div_val, div_load, frame_len,
        input  tick, sclk_sq, frame, div_ack, div_err, cnt
    );

    modport slave (
        input  en, div_val, div_load, frame_len,
        output tick, sclk_sq, frame, div_ack, div_err, cnt
    );
endinterface

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Programmable clock divider with a tick pulse, a registered square wave and
// a framing pulse every frame_len ticks. A new divisor is staged in a pending
// register and only takes effect at a period boundary, so periods are never
// cut short while counting.
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : clk_div_prog_if.slave (controls in, tick/sclk_sq/frame/div_ack/
//          div_err/cnt out)
// All outputs are registers; each output register is loaded with the value
// that matches the counter state it will be shown alongside, so tick is high
// exactly while cnt == div-1 and sclk_sq == (cnt < div/2).
// -----------------------------------------------------------------------------
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int FRM_W       = 16,
    parameter int DEFAULT_DIV = 133
) (
    input  logic           clk,
    input  logic           rst,
    clk_div_prog_if.slave  bus
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN  = DIV_W'(2);
    localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

    // state
    logic [DIV_W-1:0] div_q, div_d;            // active divisor
    logic [DIV_W-1:0] pend_val_q, pend_val_d;  // staged divisor
    logic             pend_q, pend_d;          // staged divisor valid
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [FRM_W-1:0] fcnt_q, fcnt_d;
    logic             tick_q, tick_d;
    logic             sclk_q, sclk_d;
    logic             frame_q, frame_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    // decode
    logic load_ok;
    logic load_bad;
    logic at_last;
    logic wrap;
    logic apply;

    always_comb begin
        load_ok  = bus.div_load && (bus.div_val >= DIV_MIN);
        load_bad = bus.div_load && (bus.div_val <  DIV_MIN);
        // >= rather than == so a counter left above a freshly applied
        // smaller divisor can never run on past it.
        at_last  = (cnt_q >= (div_q - DIV_ONE));
        wrap     = bus.en && at_last;
        // While stopped there is no period boundary to wait for, so a
        // pending divisor goes in on the next edge.
        apply    = pend_q && (wrap || !bus.en);

        div_d      = div_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        fcnt_d     = fcnt_q;
        frame_d    = 1'b0;
        ack_d      = 1'b0;
        err_d      = load_bad;

        if (apply) begin
            div_d  = pend_val_q;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // Evaluated after apply so a load landing on the apply edge becomes
        // the next pending value instead of being lost.
        if (load_ok) begin
            pend_val_d = bus.div_val;
            pend_d     = 1'b1;
        end

        if (bus.en) begin
            cnt_d = wrap ? '0 : cnt_q + DIV_ONE;
        end else if (apply && (cnt_q > (pend_val_q - DIV_ONE))) begin
            // Divisor shrank while stopped: park on the last count so the
            // first enabled edge wraps cleanly.
            cnt_d = pend_val_q - DIV_ONE;
        end

        tick_d = bus.en && (cnt_d == (div_d - DIV_ONE));
        sclk_d = (cnt_d < (div_d >> 1));

        if (bus.frame_len == '0) begin
            fcnt_d = '0;
        end else if (tick_d) begin
            // >= also catches frame_len lowered below the running count.
            if (fcnt_q >= (bus.frame_len - FRM_ONE)) begin
                fcnt_d  = '0;
                frame_d = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FRM_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_RST;
            pend_val_q <= DIV_RST;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            tick_q     <= 1'b0;
            sclk_q     <= 1'b0;
            frame_q    <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            fcnt_q     <= fcnt_d;
            tick_q     <= tick_d;
            sclk_q     <= sclk_d;
            frame_q    <= frame_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.sclk_sq = sclk_q;
    assign bus.frame   = frame_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.cnt     = cnt_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Directed bench for clk_div_prog. Inputs change 1 ns after the rising edge
// and outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

    localparam int DIV_W = 8;
    localparam int FRM_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    clk_div_prog_if #(.DIV_W(DIV_W), .FRM_W(FRM_W)) bus ();

    clk_div_prog #(
        .DIV_W      (DIV_W),
        .FRM_W      (FRM_W),
        .DEFAULT_DIV(133)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("ok   %s: %0d", tag, obs);
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic run_to_cnt(input int v);
        int guard = 0;
        while (int'(bus.cnt) != v && guard < 1000) begin
            step();
            guard++;
        end
        if (guard >= 1000) check_eq("timeout_cnt", int'(bus.cnt), v);
    endtask

    // Steps until tick is seen; n = number of edges taken.
    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick && n < 2000);
        if (!bus.tick) check_eq("timeout_tick", int'(bus.tick), 1);
    endtask

    // Period between two ticks and number of sclk_sq high cycles in it.
    task automatic measure(output int per, output int hi);
        int dummy;
        cycles_to_tick(dummy);
        per = 0;
        hi  = 0;
        do begin
            step();
            per++;
            hi += int'(bus.sclk_sq);
        end while (!bus.tick && per < 2000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int per, hi, n, ticks, first, bad, acks, errs, frames, mis;

        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.div_val  = '0;
        bus.div_load = 1'b0;
        bus.frame_len = '0;
        step();
        step();

        // ---- reset state, en=1 held during reset
        check_eq("rst_cnt",   int'(bus.cnt),     0);
        check_eq("rst_tick",  int'(bus.tick),    0);
        check_eq("rst_sclk",  int'(bus.sclk_sq), 0);
        check_eq("rst_frame", int'(bus.frame),   0);
        check_eq("rst_ack",   int'(bus.div_ack), 0);
        check_eq("rst_err",   int'(bus.div_err), 0);

        // ---- default divisor, 1000 clocks
        rst = 1'b0;
        step();
        check_eq("first_edge_cnt",  int'(bus.cnt),     1);
        check_eq("first_edge_sclk", int'(bus.sclk_sq), 1);
        ticks = 0; first = -1; bad = 0; acks = 0; errs = 0;
        for (int e = 2; e <= 1000; e++) begin
            step();
            if (bus.tick) begin
                ticks++;
                if (first < 0) first = e;
                if (int'(bus.cnt) != 132) bad++;
            end
            acks += int'(bus.div_ack);
            errs += int'(bus.div_err);
        end
        check_eq("first_tick_edge", first, 132);
        check_eq("ticks_in_1000",   ticks, 7);
        check_eq("tick_at_cnt132",  bad,   0);
        check_eq("idle_acks",       acks,  0);
        check_eq("idle_errs",       errs,  0);
        measure(per, hi);
        check_eq("period_133", per, 133);
        check_eq("sclk_hi_66", hi,  66);

        // ---- load 10 at cnt=50, applied at the 132 wrap
        run_to_cnt(50);
        bus.div_val  = 8'd10;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check_eq("load10_cnt", int'(bus.cnt),     51);
        check_eq("load10_ack", int'(bus.div_ack), 0);
        acks = 0; n = 0;
        while (int'(bus.cnt) != 132 && n < 200) begin
            step();
            n++;
            acks += int'(bus.div_ack);
        end
        check_eq("load10_early_ack", acks, 0);
        check_eq("load10_tick132", int'(bus.tick), 1);
        step();
        check_eq("load10_wrap_cnt", int'(bus.cnt),     0);
        check_eq("load10_wrap_ack", int'(bus.div_ack), 1);
        step();
        check_eq("load10_ack_drop", int'(bus.div_ack), 0);
        measure(per, hi);
        check_eq("period_10", per, 10);
        check_eq("sclk_hi_5", hi,  5);

        // ---- rejected loads, then back-to-back loads
        do_reset();
        bus.div_val  = 8'd1;
        bus.div_load = 1'b1;
        step();
        check_eq("err_div1", int'(bus.div_err), 1);
        bus.div_val = 8'd0;
        step();
        check_eq("err_div0", int'(bus.div_err), 1);
        bus.div_load = 1'b0;
        step();
        check_eq("err_drop", int'(bus.div_err), 0);
        measure(per, hi);
        check_eq("period_after_err", per, 133);
        bus.div_val  = 8'd20;
        bus.div_load = 1'b1;
        step();
        bus.div_val = 8'd30;
        step();
        bus.div_load = 1'b0;
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            acks += int'(bus.div_ack);
        end
        check_eq("b2b_single_ack", acks, 1);
        measure(per, hi);
        check_eq("period_30",  per, 30);
        check_eq("sclk_hi_15", hi,  15);

        // ---- framing with div=4
        bus.frame_len = 16'd3;
        do_reset();
        bus.div_val  = 8'd4;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        n = 0;
        while (!bus.div_ack && n < 300) begin
            step();
            n++;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.frame && n < 100);
        n = 0; ticks = 0; mis = 0;
        do begin
            step();
            n++;
            ticks += int'(bus.tick);
            if (bus.frame && !bus.tick) mis++;
        end while (!bus.frame && n < 100);
        check_eq("frame_interval_12", n,     12);
        check_eq("frame_ticks_3",     ticks, 3);
        check_eq("frame_on_tick",     mis,   0);
        bus.frame_len = 16'd0;
        frames = 0; ticks = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            frames += int'(bus.frame);
            ticks  += int'(bus.tick);
        end
        check_eq("flen0_frames", frames, 0);
        check_eq("flen0_ticks",  ticks,  12);
        bus.frame_len = 16'd1;
        frames = 0; mis = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            frames += int'(bus.frame);
            if (bus.frame != bus.tick) mis++;
        end
        check_eq("flen1_frames",     frames, 10);
        check_eq("flen1_frame_tick", mis,    0);
        bus.frame_len = 16'd0;

        // ---- en pause of 7 clocks at cnt=2
        do_reset();
        run_to_cnt(2);
        bus.en = 1'b0;
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (int'(bus.cnt) != 2) bad++;
            if (bus.tick) bad++;
        end
        check_eq("pause_hold", bad, 0);
        bus.en = 1'b1;
        cycles_to_tick(n);
        check_eq("pause_latency", n + 7, 137);

        // ---- reset mid-period with a load pending
        do_reset();
        run_to_cnt(20);
        bus.div_val  = 8'd10;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        run_to_cnt(70);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mid_rst_cnt",  int'(bus.cnt),     0);
        check_eq("mid_rst_sclk", int'(bus.sclk_sq), 0);
        check_eq("mid_rst_tick", int'(bus.tick),    0);
        check_eq("mid_rst_ack",  int'(bus.div_ack), 0);
        acks = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            acks += int'(bus.div_ack);
        end
        check_eq("mid_rst_no_ack", acks, 0);
        measure(per, hi);
        check_eq("mid_rst_period", per, 133);

        // ---- apply while stopped, then load on the apply edge
        run_to_cnt(3);
        bus.en       = 1'b0;
        bus.div_val  = 8'd6;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check_eq("stopped_load_ack", int'(bus.div_ack), 0);
        step();
        check_eq("stopped_apply_ack", int'(bus.div_ack), 1);
        check_eq("stopped_apply_cnt", int'(bus.cnt),     3);
        bus.en = 1'b1;
        measure(per, hi);
        check_eq("period_6",  per, 6);
        check_eq("sclk_hi_3", hi,  3);
        step();
        bus.div_val  = 8'd12;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        run_to_cnt(5);
        bus.div_val  = 8'd8;
        bus.div_load = 1'b1;
        step();
        bus.div_load = 1'b0;
        check_eq("apply12_ack", int'(bus.div_ack), 1);
        check_eq("apply12_cnt", int'(bus.cnt),     0);
        cycles_to_tick(n);
        check_eq("period12_to_tick", n, 11);
        step();
        check_eq("apply8_ack", int'(bus.div_ack), 1);
        measure(per, hi);
        check_eq("period_8",  per, 8);
        check_eq("sclk_hi_4", hi,  4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
